// File: rtl/graph_pkg.sv
// Shared sizing defaults and packer state encoding for the vid bank packer and master_top.
package graph_pkg;
  localparam int K_DEF          = 16;
  localparam int Q_DEF          = 16;
  localparam int VID_BW_DEF     = 16;
  localparam int ADDR_SPACE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pack_state_t;
endpackage

// File: rtl/vid_bank_lane.sv
// One bank's packer: appends incoming vids to a partial line, emits full or flushed
// lines with the bank's line address, and drops lines once the address space is used up.
module vid_bank_lane
  import graph_pkg::*;
#(
  parameter int              Q          = Q_DEF,
  parameter int              VID_BW     = VID_BW_DEF,
  parameter int              ADDR_SPACE = ADDR_SPACE_DEF,
  parameter logic [VID_BW-1:0] PAD      = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic                  accept,
  input  logic                  flush_issue,
  input  logic [Q-1:0]          hit,
  input  logic [Q*VID_BW-1:0]   in_vid,
  output logic                  wsb,
  output logic [Q*VID_BW-1:0]   wdata,
  output logic [ADDR_SPACE-1:0] waddr,
  output logic                  overflow
);
  localparam int FW = $clog2(Q);
  localparam int TW = $clog2(2 * Q);
  localparam int PW = (Q - 1) * VID_BW;
  localparam logic [TW-1:0]       Q_T     = TW'(Q);
  localparam logic [ADDR_SPACE:0] CNT_ONE = (ADDR_SPACE + 1)'(1);

  logic [PW-1:0]       pend, pend_nx;
  logic [FW-1:0]       fill, fill_nx;
  logic [ADDR_SPACE:0] line_cnt;
  logic [VID_BW-1:0]   ext [2*Q];
  logic [TW-1:0]       pos;
  logic [Q*VID_BW-1:0] line;
  logic                line_full;
  logic                line_fire;

  // Pending vids followed by this beat's hits, compacted in lane order; slots past the
  // data hold PAD so a flushed partial line is already padded.
  always_comb begin
    for (int j = 0; j < 2 * Q; j++) ext[j] = PAD;
    for (int j = 0; j < Q - 1; j++) begin
      if (j < int'(fill)) ext[j] = pend[j*VID_BW +: VID_BW];
    end
    pos = TW'(fill);
    for (int i = 0; i < Q; i++) begin
      if (hit[i]) begin
        ext[pos] = in_vid[i*VID_BW +: VID_BW];
        pos = pos + TW'(1);
      end
    end
    line = '0;
    for (int s = 0; s < Q; s++) line[s*VID_BW +: VID_BW] = ext[s];
    line_full = (pos >= Q_T);
    fill_nx   = line_full ? FW'(pos - Q_T) : FW'(pos);
    pend_nx   = '0;
    for (int j = 0; j < Q - 1; j++) begin
      pend_nx[j*VID_BW +: VID_BW] = line_full ? ext[Q + j] : ext[j];
    end
    line_fire = accept ? line_full : (flush_issue && (fill != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= '0;
      line_cnt <= '0;
      wsb      <= 1'b1;
      wdata    <= '0;
      waddr    <= '0;
      overflow <= 1'b0;
    end else begin
      wsb <= 1'b1;
      if (restart) begin
        fill     <= '0;
        line_cnt <= '0;
      end else if (accept || flush_issue) begin
        fill <= flush_issue ? '0 : fill_nx;
        if (line_fire) begin
          // The top counter bit marks an exhausted address space.
          if (line_cnt[ADDR_SPACE]) begin
            overflow <= 1'b1;
          end else begin
            wsb      <= 1'b0;
            wdata    <= line;
            waddr    <= line_cnt[ADDR_SPACE-1:0];
            line_cnt <= line_cnt + CNT_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !restart) pend <= pend_nx;
  end
endmodule

// File: rtl/vid_bank_packer.sv
// Routes each beat's lanes to K per-bank packers and sequences flush/done around them.
module vid_bank_packer
  import graph_pkg::*;
#(
  parameter int                K          = K_DEF,
  parameter int                Q          = Q_DEF,
  parameter int                VID_BW     = VID_BW_DEF,
  parameter int                ADDR_SPACE = ADDR_SPACE_DEF,
  parameter int                NEXT_BW    = $clog2(K),
  parameter logic [VID_BW-1:0] PAD        = '1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      restart,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Q-1:0]              in_mask,
  input  logic [Q*NEXT_BW-1:0]      in_bank,
  input  logic [Q*VID_BW-1:0]       in_vid,
  input  logic                      flush,
  output logic [K-1:0]              wsb,
  output logic [K*Q*VID_BW-1:0]     wdata,
  output logic [K*ADDR_SPACE-1:0]   waddr,
  output logic                      done,
  output logic                      overflow
);
  pack_state_t state, state_nx;
  logic        accept;
  logic        flush_issue;
  logic [K-1:0] lane_ovf;

  assign in_ready    = (state == IDLE) || (state == RUN);
  assign accept      = in_valid && in_ready && !restart;
  assign flush_issue = (state == FLUSH) && !restart;
  assign overflow    = |lane_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DONE) && !restart;
    end
  end

  // A flush raised alongside a beat moves to FLUSH only after that beat is absorbed.
  always_comb begin
    state_nx = state;
    if (restart) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (flush)         state_nx = FLUSH;
          else if (in_valid) state_nx = RUN;
        end
        FLUSH:   state_nx = DONE;
        DONE:    state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < K; b++) begin : g_bank
    logic [Q-1:0] hit;

    always_comb begin
      hit = '0;
      for (int i = 0; i < Q; i++) begin
        hit[i] = in_mask[i] && (in_bank[i*NEXT_BW +: NEXT_BW] == NEXT_BW'(b));
      end
    end

    vid_bank_lane #(
      .Q          (Q),
      .VID_BW     (VID_BW),
      .ADDR_SPACE (ADDR_SPACE),
      .PAD        (PAD)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .restart     (restart),
      .accept      (accept),
      .flush_issue (flush_issue),
      .hit         (hit),
      .in_vid      (in_vid),
      .wsb         (wsb[b]),
      .wdata       (wdata[b*Q*VID_BW +: Q*VID_BW]),
      .waddr       (waddr[b*ADDR_SPACE +: ADDR_SPACE]),
      .overflow    (lane_ovf[b])
    );
  end
endmodule

// File: tb/tb_vid_bank_packer.sv
// Directed and randomized checks of vid_bank_packer at default parameters.
module tb_vid_bank_packer;
  localparam int K  = 16;
  localparam int Q  = 16;
  localparam int VB = 16;
  localparam int AS = 4;
  localparam int NB = 4;

  logic              clk;
  logic              rst_n;
  logic              restart;
  logic              in_valid;
  logic              in_ready;
  logic [Q-1:0]      in_mask;
  logic [Q*NB-1:0]   in_bank;
  logic [Q*VB-1:0]   in_vid;
  logic              flush;
  logic [K-1:0]      wsb;
  logic [K*Q*VB-1:0] wdata;
  logic [K*AS-1:0]   waddr;
  logic              done;
  logic              overflow;

  int total;
  int bad;

  vid_bank_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mask  (in_mask),
    .in_bank  (in_bank),
    .in_vid   (in_vid),
    .flush    (flush),
    .wsb      (wsb),
    .wdata    (wdata),
    .waddr    (waddr),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  mask;
    logic [3:0]   bank;
    logic [15:0]  vid0;
    logic [15:0]  exp_wsb;
    logic [3:0]   exp_addr;
    logic [255:0] exp_line;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] mask, input logic [63:0] banks,
                               input logic [255:0] vids, input logic fl, input logic rs);
    in_valid = v;
    in_mask  = mask;
    in_bank  = banks;
    in_vid   = vids;
    flush    = fl;
    restart  = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] all_bank(input logic [3:0] b);
    logic [63:0] r;
    for (int i = 0; i < Q; i++) r[i*NB +: NB] = b;
    return r;
  endfunction

  function automatic logic [255:0] strided(input logic [15:0] base, input logic [15:0] step);
    logic [255:0] r;
    for (int i = 0; i < Q; i++) r[i*VB +: VB] = base + step * 16'(i);
    return r;
  endfunction

  function automatic logic [255:0] half_mix(input logic [255:0] lo, input logic [255:0] hi);
    return {hi[255:128], lo[127:0]};
  endfunction

  function automatic logic [255:0] bank_line(input int b);
    return wdata[b*Q*VB +: Q*VB];
  endfunction

  function automatic logic [3:0] bank_addr(input int b);
    return waddr[b*AS +: AS];
  endfunction

  logic [15:0]  mq [16][$];
  int           mcnt [16];
  int           pushed;
  int           written;
  int           next_vid;
  logic [15:0]  exp_wsb;
  logic [255:0] exp_line [16];
  logic [3:0]   exp_addr [16];
  logic [255:0] tmp;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    restart = 1'b0; in_valid = 1'b0; in_mask = '0; in_bank = '0; in_vid = '0; flush = 1'b0;
    #12;
    checkOutput("reset wsb", 256'(wsb), 256'(16'hFFFF));
    checkOutput("reset wdata", 256'(|wdata), 256'(1'b0));
    checkOutput("reset waddr", 256'(waddr), 256'(0));
    checkOutput("reset done", 256'(done), 256'(0));
    checkOutput("reset overflow", 256'(overflow), 256'(0));
    checkOutput("reset in_ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{16'hFFFF, 4'd3, 16'd0,   16'hFFF7, 4'd0, strided(16'd0, 16'd1)};
    vecs[1] = '{16'h00FF, 4'd0, 16'd100, 16'hFFFF, 4'd0, 256'h0};
    vecs[2] = '{16'h00FF, 4'd0, 16'd200, 16'hFFFE, 4'd0,
                half_mix(strided(16'd100, 16'd1), strided(16'd192, 16'd1))};
    vecs[3] = '{16'hFFFF, 4'd3, 16'd50,  16'hFFF7, 4'd1, strided(16'd50, 16'd1)};
    vecs[4] = '{16'h0000, 4'd9, 16'd900, 16'hFFFF, 4'd0, 256'h0};
    vecs[5] = '{16'hAAAA, 4'd9, 16'd300, 16'hFFFF, 4'd0, 256'h0};
    vecs[6] = '{16'h5555, 4'd9, 16'd400, 16'hFDFF, 4'd0,
                half_mix(strided(16'd301, 16'd2), strided(16'd384, 16'd2))};

    for (int n = 0; n < 7; n++) begin
      applyStimulus(1'b1, vecs[n].mask, all_bank(vecs[n].bank), strided(vecs[n].vid0, 16'd1), 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d wsb", n), 256'(wsb), 256'(vecs[n].exp_wsb));
      if (vecs[n].exp_wsb != 16'hFFFF) begin
        checkOutput($sformatf("vec%0d waddr", n), 256'(bank_addr(int'(vecs[n].bank))), 256'(vecs[n].exp_addr));
        checkOutput($sformatf("vec%0d wdata", n), bank_line(int'(vecs[n].bank)), vecs[n].exp_line);
      end
    end

    // Line split across beats, then a padded flush write and the done pulse.
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h03FF, all_bank(4'd5), strided(16'd500, 16'd1), 1'b0, 1'b0);
    checkOutput("split beat1 wsb", 256'(wsb), 256'(16'hFFFF));
    applyStimulus(1'b1, 16'hFFFF, all_bank(4'd5), strided(16'd600, 16'd1), 1'b0, 1'b0);
    for (int s = 0; s < Q; s++) tmp[s*VB +: VB] = (s < 10) ? 16'(500 + s) : 16'(590 + s);
    checkOutput("split beat2 wsb", 256'(wsb), 256'(16'hFFDF));
    checkOutput("split beat2 wdata", bank_line(5), tmp);
    checkOutput("split beat2 waddr", 256'(bank_addr(5)), 256'(0));
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b1, 1'b0);
    checkOutput("flush issue in_ready", 256'(in_ready), 256'(0));
    checkOutput("flush issue wsb", 256'(wsb), 256'(16'hFFFF));
    idleStep();
    for (int s = 0; s < Q; s++) tmp[s*VB +: VB] = (s < 10) ? 16'(606 + s) : 16'hFFFF;
    checkOutput("flush wsb", 256'(wsb), 256'(16'hFFDF));
    checkOutput("flush wdata", bank_line(5), tmp);
    checkOutput("flush waddr", 256'(bank_addr(5)), 256'(1));
    checkOutput("flush done early", 256'(done), 256'(0));
    checkOutput("flush in_ready", 256'(in_ready), 256'(0));
    idleStep();
    checkOutput("flush done", 256'(done), 256'(1));
    checkOutput("flush after wsb", 256'(wsb), 256'(16'hFFFF));
    checkOutput("flush after in_ready", 256'(in_ready), 256'(1));
    idleStep();
    checkOutput("flush done width", 256'(done), 256'(0));

    // Address space exhaustion on bank 7.
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b0, 1'b1);
    checkOutput("ovf start", 256'(overflow), 256'(0));
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b1, 16'hFFFF, all_bank(4'd7), strided(16'(16 * k), 16'd1), 1'b0, 1'b0);
      if (k < 16) begin
        checkOutput($sformatf("ovf line%0d wsb", k), 256'(wsb), 256'(16'hFF7F));
        checkOutput($sformatf("ovf line%0d waddr", k), 256'(bank_addr(7)), 256'(k));
      end else begin
        checkOutput("ovf drop wsb", 256'(wsb), 256'(16'hFFFF));
        checkOutput("ovf flag", 256'(overflow), 256'(1));
      end
    end

    // Reset while bank 2 holds a partial line.
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h001F, all_bank(4'd2), strided(16'd700, 16'd1), 1'b0, 1'b0);
    checkOutput("rst partial wsb", 256'(wsb), 256'(16'hFFFF));
    in_valid = 1'b0; in_mask = '0;
    rst_n = 1'b0;
    #2;
    checkOutput("rst mid wsb", 256'(wsb), 256'(16'hFFFF));
    checkOutput("rst mid overflow", 256'(overflow), 256'(0));
    checkOutput("rst mid waddr", 256'(waddr), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b1, 1'b0);
    checkOutput("rst flush issue wsb", 256'(wsb), 256'(16'hFFFF));
    idleStep();
    checkOutput("rst flush nowrite", 256'(wsb), 256'(16'hFFFF));
    checkOutput("rst flush done early", 256'(done), 256'(0));
    idleStep();
    checkOutput("rst flush done", 256'(done), 256'(1));
    applyStimulus(1'b1, 16'hFFFF, all_bank(4'd2), strided(16'd800, 16'd1), 1'b0, 1'b0);
    checkOutput("rst fresh wsb", 256'(wsb), 256'(16'hFFFB));
    checkOutput("rst fresh wdata", bank_line(2), strided(16'd800, 16'd1));

    // Randomized lanes against a queue-per-bank reference.
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b0, 1'b1);
    for (int b = 0; b < K; b++) begin
      mq[b].delete();
      mcnt[b] = 0;
    end
    pushed = 0;
    written = 0;
    next_vid = 1000;
    for (int n = 0; n < 300; n++) begin
      logic        v;
      logic [15:0] mask;
      logic [63:0] banks;
      logic [255:0] vids;
      v     = ($urandom_range(3) != 0);
      mask  = 16'($urandom());
      banks = {$urandom(), $urandom()};
      for (int i = 0; i < Q; i++) vids[i*VB +: VB] = 16'(next_vid + i);
      next_vid += Q;
      applyStimulus(v, mask, banks, vids, 1'b0, 1'b0);
      exp_wsb = 16'hFFFF;
      if (v) begin
        for (int i = 0; i < Q; i++) begin
          if (mask[i]) begin
            mq[int'(banks[i*NB +: NB])].push_back(vids[i*VB +: VB]);
            pushed++;
          end
        end
        for (int b = 0; b < K; b++) begin
          if (mq[b].size() >= Q) begin
            for (int s = 0; s < Q; s++) exp_line[b][s*VB +: VB] = mq[b].pop_front();
            exp_addr[b] = 4'(mcnt[b]);
            mcnt[b]++;
            exp_wsb[b] = 1'b0;
          end
        end
      end
      checkOutput($sformatf("rand%0d wsb", n), 256'(wsb), 256'(exp_wsb));
      for (int b = 0; b < K; b++) begin
        if (!exp_wsb[b]) begin
          checkOutput($sformatf("rand%0d b%0d wdata", n, b), bank_line(b), exp_line[b]);
          checkOutput($sformatf("rand%0d b%0d waddr", n, b), 256'(bank_addr(b)), 256'(exp_addr[b]));
          written += Q;
        end
      end
    end
    applyStimulus(1'b0, 16'h0, 64'h0, 256'h0, 1'b1, 1'b0);
    idleStep();
    exp_wsb = 16'hFFFF;
    for (int b = 0; b < K; b++) begin
      if (mq[b].size() > 0) begin
        exp_wsb[b] = 1'b0;
        written += mq[b].size();
        for (int s = 0; s < Q; s++) exp_line[b][s*VB +: VB] = (mq[b].size() > 0) ? mq[b].pop_front() : 16'hFFFF;
        exp_addr[b] = 4'(mcnt[b]);
      end
    end
    checkOutput("rand flush wsb", 256'(wsb), 256'(exp_wsb));
    for (int b = 0; b < K; b++) begin
      if (!exp_wsb[b]) begin
        checkOutput($sformatf("rand flush b%0d wdata", b), bank_line(b), exp_line[b]);
        checkOutput($sformatf("rand flush b%0d waddr", b), 256'(bank_addr(b)), 256'(exp_addr[b]));
      end
    end
    idleStep();
    checkOutput("rand done", 256'(done), 256'(1));
    checkOutput("rand lane count", 256'(written), 256'(pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
